// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage.
//   fetch_state_e    : fetch FSM states (request, wait for data, hold for decode)
//   NOP_INST         : canonical RISC-V NOP (addi x0, x0, 0)
//   INST_BYTES       : bytes per instruction word (PC increment)
//   DEFAULT_RESET_PC : default PC loaded on reset
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam int          INST_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch stage.
// Next-PC priority: reset > redirect > increment > hold.
// Ports:
//   clk            in   clock
//   reset          in   asynchronous, active-low reset (loads RESET_PC)
//   redirect_valid in   load redirect_pc (low two bits cleared)
//   redirect_pc    in   redirect target
//   incr           in   advance the PC by one instruction
//   pc             out  current PC
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            incr,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;

  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid) begin
      // Targets are always word aligned; low bits from execute are ignored.
      pc_next = redirect_pc & ~XLEN'(3);
    end else if (incr) begin
      pc_next = pc_reg + XLEN'(INST_BYTES);  // wraps modulo 2^XLEN
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Multicycle fetch stage: owns the PC, issues one instruction-memory request
// at a time, latches the returned word and offers {pc, inst} to decode over a
// valid/ready handshake. Redirects from execute win over every other event
// and cause any in-flight response to be discarded.
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   imem_req/imem_addr  fetch request and word-aligned address (out)
//   imem_gnt            memory accepted the request (in)
//   imem_rvalid/rdata   returned instruction word (in)
//   redirect_valid/pc   PC change request from execute (in)
//   id_valid/id_ready   handshake with decode
//   id_inst/id_pc       instruction word and its PC (out, registered)
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc
);

  fetch_state_e    state_reg, state_next;
  logic            drop_reg, drop_next;
  logic            id_valid_reg, id_valid_next;
  logic [XLEN-1:0] id_inst_reg, id_inst_next;
  logic [XLEN-1:0] id_pc_reg, id_pc_next;
  logic            pc_incr;
  logic [XLEN-1:0] pc;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .XLEN     (XLEN)
  ) u_pc_reg (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .incr           (pc_incr),
    .pc             (pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_REQ;
      drop_reg     <= 1'b0;
      id_valid_reg <= 1'b0;
      id_inst_reg  <= NOP_INST;
      id_pc_reg    <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      drop_reg     <= drop_next;
      id_valid_reg <= id_valid_next;
      id_inst_reg  <= id_inst_next;
      id_pc_reg    <= id_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    drop_next     = drop_reg;
    id_valid_next = id_valid_reg;
    id_inst_next  = id_inst_reg;
    id_pc_next    = id_pc_reg;
    pc_incr       = 1'b0;
    // Request is suppressed while reset is held so memory sees no request
    // before the unit is released.
    imem_req      = (state_reg == ST_REQ) && reset;
    imem_addr     = pc;

    if (redirect_valid) begin
      id_valid_next = 1'b0;
      unique case (state_reg)
        ST_REQ: begin
          // A grant in this cycle means the old-PC request is already out.
          if (imem_gnt) begin
            drop_next  = 1'b1;
            state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            drop_next  = 1'b0;
            state_next = ST_REQ;
          end else begin
            drop_next  = 1'b1;
          end
        end
        ST_HOLD: begin
          // Any id_ready this cycle is ignored; no increment is applied.
          state_next = ST_REQ;
        end
        default: state_next = ST_REQ;
      endcase
    end else begin
      unique case (state_reg)
        ST_REQ: begin
          if (imem_gnt) state_next = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (drop_reg) begin
              drop_next  = 1'b0;
              state_next = ST_REQ;
            end else begin
              id_inst_next  = imem_rdata;
              id_pc_next    = pc;
              id_valid_next = 1'b1;
              state_next    = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (id_ready) begin
            id_valid_next = 1'b0;
            pc_incr       = 1'b1;
            state_next    = ST_REQ;
          end
        end
        default: state_next = ST_REQ;
      endcase
    end
  end

  assign id_valid = id_valid_reg;
  assign id_inst  = id_inst_reg;
  assign id_pc    = id_pc_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  // Second instance exercising PC wrap from the top of the address space.
  logic        reset_w;
  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic        imem_gnt_w;
  logic        imem_rvalid_w;
  logic [31:0] imem_rdata_w;
  logic        redirect_valid_w;
  logic [31:0] redirect_pc_w;
  logic        id_valid_w;
  logic        id_ready_w;
  logic [31:0] id_inst_w;
  logic [31:0] id_pc_w;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .reset          (reset_w),
    .imem_req       (imem_req_w),
    .imem_addr      (imem_addr_w),
    .imem_gnt       (imem_gnt_w),
    .imem_rvalid    (imem_rvalid_w),
    .imem_rdata     (imem_rdata_w),
    .redirect_valid (redirect_valid_w),
    .redirect_pc    (redirect_pc_w),
    .id_valid       (id_valid_w),
    .id_ready       (id_ready_w),
    .id_inst        (id_inst_w),
    .id_pc          (id_pc_w)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  fetch_t exp_q[$];
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the instruction presented to decode against the oldest expected
  // entry; pop it only when decode will take it.
  task automatic sb_check(input string tag, input bit pop);
    fetch_t e;
    check({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
    n_cmp++;
    assert (exp_q.size() > 0) else begin
      n_err++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      check({tag, "_pc"}, id_pc, e.pc);
      check({tag, "_inst"}, id_inst, e.inst);
      if (pop) void'(exp_q.pop_front());
    end
    $display("txn %s: id_pc=%h id_inst=%h", tag, id_pc, id_inst);
  endtask

  // Normal fetch from REQ: grant now, data next cycle, then present to decode.
  task automatic fetch(input logic [31:0] exp_pc, input logic [31:0] word);
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    exp_q.push_back('{pc: exp_pc, inst: word});
    tick();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    reset_w = 1'b0; imem_gnt_w = 1'b0; imem_rvalid_w = 1'b0; imem_rdata_w = '0;
    redirect_valid_w = 1'b0; redirect_pc_w = '0; id_ready_w = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'd0, id_valid}, 32'd0);
    check("rst_inst", id_inst, 32'h0000_0013);
    check("rst_pc", id_pc, 32'h0);
    reset = 1'b1;
    #1;

    // First fetch: id_valid two cycles after REQ
    fetch(32'h0, 32'h0050_0093);
    sb_check("first", 1'b1);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("first_next_addr", imem_addr, 32'h4);
    check("first_valid_clr", {31'd0, id_valid}, 32'd0);

    // Decode stall for 5 cycles
    fetch(32'h4, 32'hAABB_CCDD);
    for (int i = 0; i < 5; i++) begin
      sb_check("stall", 1'b0);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      tick();
    end
    sb_check("stall_end", 1'b1);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("stall_next_addr", imem_addr, 32'h8);

    // Redirect and id_ready together in HOLD: redirect wins
    fetch(32'h8, 32'h1234_5678);
    sb_check("hold_redir", 1'b1);
    id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    id_ready = 1'b0; redirect_valid = 1'b0;
    check("hold_redir_addr", imem_addr, 32'h40);
    check("hold_redir_valid", {31'd0, id_valid}, 32'd0);

    // Redirect while WAIT; stale data arrives 3 cycles later and is dropped
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("wait_redir_req", {31'd0, imem_req}, 32'd0);
      tick();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("drop_valid", {31'd0, id_valid}, 32'd0);
    check("drop_req", {31'd0, imem_req}, 32'd1);
    check("drop_addr", imem_addr, 32'h100);
    tick();
    check("drop_valid2", {31'd0, id_valid}, 32'd0);
    fetch(32'h100, 32'h0000_0513);
    sb_check("after_drop", 1'b1);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    check("after_drop_addr", imem_addr, 32'h104);

    // Redirect in REQ without grant: stay in REQ at new PC
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    tick();
    redirect_valid = 1'b0;
    check("req_redir_req", {31'd0, imem_req}, 32'd1);
    check("req_redir_addr", imem_addr, 32'h200);

    // Redirect in REQ with grant: the response to the old request is dropped
    imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    imem_gnt = 1'b0; redirect_valid = 1'b0;
    check("req_gnt_redir_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_rvalid = 1'b0;
    check("req_gnt_drop_valid", {31'd0, id_valid}, 32'd0);
    check("req_gnt_drop_addr", imem_addr, 32'h300);

    // Reset asserted in WAIT, rvalid during reset
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_addr", imem_addr, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0BAD;
    tick();
    imem_rvalid = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("postrst_valid", {31'd0, id_valid}, 32'd0);
    check("postrst_addr", imem_addr, 32'h0);
    check("postrst_req", {31'd0, imem_req}, 32'd1);
    tick();
    check("postrst_valid2", {31'd0, id_valid}, 32'd0);
    check("sb_empty", exp_q.size(), 32'd0);

    // PC wrap from RESET_PC = 0xFFFF_FFFC
    reset_w = 1'b1;
    #1;
    check("wrap_addr0", imem_addr_w, 32'hFFFF_FFFC);
    imem_gnt_w = 1'b1;
    tick();
    imem_gnt_w = 1'b0; imem_rvalid_w = 1'b1; imem_rdata_w = 32'h0010_0073;
    tick();
    imem_rvalid_w = 1'b0;
    check("wrap_valid", {31'd0, id_valid_w}, 32'd1);
    check("wrap_pc", id_pc_w, 32'hFFFF_FFFC);
    check("wrap_inst", id_inst_w, 32'h0010_0073);
    $display("txn wrap: id_pc=%h id_inst=%h", id_pc_w, id_inst_w);
    id_ready_w = 1'b1;
    tick();
    id_ready_w = 1'b0;
    check("wrap_next_addr", imem_addr_w, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Multicycle RISC-V fetch stage: owns the PC, requests instruction words from instruction memory, and latches each returned word.
- Presents {pc, inst} to decode (immediate generator, control unit, register file) over a valid/ready handshake.
- Accepts branch/jump redirects from execute and discards any stale in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1 and imem_gnt=0.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; exactly one per granted request, earliest the cycle after the grant.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  execute requests a PC change (taken branch, JAL, JALR).
- redirect_pc  in  32  target PC; bits [1:0] are forced to 0 internally.
- id_valid  out  1  id_inst/id_pc hold a valid instruction.
- id_ready  in  1  decode consumes the instruction this cycle.
- id_inst  out  32  instruction word to decode.
- id_pc  out  32  PC of id_inst.

Behaviour:
- Reset (async assert, sync deassert handled externally): pc=RESET_PC, state=REQ, drop=0, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=RESET_PC.
- All outputs are registered except imem_req and imem_addr, which are decoded from state and pc.
- States:
  - REQ: imem_req=1, imem_addr=pc. On imem_gnt, go to WAIT.
  - WAIT: wait for imem_rvalid. When it arrives: if drop=0, capture id_inst=imem_rdata, id_pc=pc, set id_valid, go to HOLD. If drop=1, discard the data, clear drop, go to REQ.
  - HOLD: id_valid=1; outputs stay stable until id_ready. On id_ready: clear id_valid, set pc=pc+4 (modulo 2^32; wraps to 0), go to REQ.
- Latency: grant in the REQ cycle plus rvalid one cycle later means id_valid rises 2 cycles after REQ is entered. Peak throughput is 1 instruction per 3 cycles.
- Redirect has priority over every other event in the same cycle:
  - pc <= {redirect_pc[31:2], 2'b00}, id_valid <= 0.
  - From REQ with gnt=0: stay in REQ at the new pc.
  - From REQ with gnt=1: the old request is in flight; set drop=1, go to WAIT.
  - From WAIT with rvalid=0: set drop=1, stay in WAIT.
  - From WAIT with rvalid=1: discard the data, go to REQ.
  - From HOLD: go to REQ. An id_ready in the same cycle is ignored; no pc+4 is applied.
- Consecutive redirects: the last one wins; drop never counts above 1 because only one request is outstanding at a time.
- imem_req is never asserted in WAIT or HOLD. At most one outstanding request at any time.
- A reset asserted mid-transaction returns to reset values immediately. Any rvalid arriving after reset while the unit is in REQ state is ignored.

Decomposition:
- Shared package (cpu_pkg): fetch state enum {REQ, WAIT, HOLD}, NOP_INST = 32'h0000_0013, INST_BYTES = 4, default RESET_PC.
- Opcode constants stay in the existing opcodes include.
- One sub-module: fetch_pc_reg. Holds the PC register with priority next-PC mux (reset > redirect > increment > hold).

Test Plan:
- Reset release, gnt=1 immediate, rvalid one cycle later with rdata=32'h00500093, id_ready=1 → id_valid high 2 cycles after REQ, id_pc=0, id_inst=32'h00500093; next imem_addr=32'h4.
- id_ready held 0 for 5 cycles in HOLD → id_inst/id_pc stable, imem_req=0 throughout; on id_ready=1, next imem_addr=pc+4.
- Redirect to 32'h0000_0103 while in WAIT, rvalid arrives 3 cycles later → that data is dropped, no id_valid pulse, next imem_addr=32'h0000_0100.
- Redirect and id_ready in the same HOLD cycle with pc=8, redirect_pc=32'h40 → next imem_addr=32'h40, not 32'hC.
- RESET_PC=32'hFFFF_FFFC, one fetch consumed → next imem_addr wraps to 32'h0.
- Reset asserted in WAIT, rvalid arrives during reset, reset released → id_valid stays 0, imem_addr=RESET_PC.
